led_pwm_ctrl: RTL and testbench
===============================

Name: led_pwm_ctrl

Overview:
- Output-side companion to the board's key-input path. It drives the four board LEDs (LED1~LED4) with per-LED brightness and display modes.
- Modes: off, steady on, blink and breathe.
- Control is through a valid/ready command port, typically fed by key-event or UI logic.
- Mode and level changes take effect only at PWM frame boundaries, so the LEDs never glitch mid-frame.

Parameters:
- TICK_DIV, 3125: sys_clk cycles per PWM tick. At 200 MHz this gives a 64 kHz tick and a 250 Hz frame of 256 ticks.
- BLINK_FRAMES, 125: PWM frames per blink half-period (0.5 s at defaults).
- LED_ACTIVE_LOW, 0: 1 inverts led_out so that a logic 0 lights the LED.

Ports:
- sys_clk  input  1  system clock, single-ended, 200 MHz
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  block can accept a command this cycle
- cmd_led  input  2  target LED index, 0..3
- cmd_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=BREATHE
- cmd_level  input  8  brightness ceiling, 0..255
- frame_sync  output  1  one-cycle pulse on the last cycle of each PWM frame
- led_out  output  4  LED drive, bit n drives LEDn+1

Behaviour:
- Clocking and reset: one clock domain, sys_clk. Reset is asynchronous and active-high (rst); all state clears immediately on rst assert.
- Reset values:
  - cmd_ready=1, frame_sync=0.
  - led_out = all LEDs unlit: 4'b0000, or 4'b1111 when LED_ACTIVE_LOW=1.
  - mode=OFF and level=0 for all LEDs.
  - All counters 0, breathe direction = up, blink_phase=0, pending slot empty.
- Prescaler:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick is high for one cycle when tick_cnt==TICK_DIV-1.
- PWM counter:
  - pwm_cnt is 8 bits and increments on tick, wrapping 255->0.
  - frame_end = tick && pwm_cnt==255.
  - frame_sync is frame_end registered, so it lags frame_end by 1 cycle.
- Blink:
  - blink_cnt counts frame_end events 0..BLINK_FRAMES-1.
  - On wrap, blink_phase toggles.
- Breathe:
  - A shared 8-bit bri moves by 1 on each frame_end.
  - Direction up: at 255, flip to down and step to 254.
  - Direction down: at 0, flip to up and step to 1.
  - Resulting sequence: 0,1,...,255,254,...,0,1,...
- Effective duty per LED:
  - OFF -> 0
  - ON -> level
  - BLINK -> level when blink_phase=1, else 0
  - BREATHE -> min(bri, level)
- Lit condition: LED is lit iff duty==255 OR pwm_cnt < duty.
  - duty 0 means always dark.
  - duty 255 means always lit, with no one-tick gap.
- Output timing: led_out is registered, 1 cycle after the pwm_cnt/duty it reflects. Polarity is applied at the output register.
- Command handshake:
  - A command is accepted when cmd_valid && cmd_ready. {led,mode,level} is stored in a single pending slot.
  - cmd_ready falls the cycle after acceptance and stays low until the pending command is applied.
  - Apply happens on the next frame_end cycle: that LED's mode and level registers update at that edge. cmd_ready returns to 1 on the following cycle.
  - Acceptance on the same cycle as frame_end: the command is applied at the next frame_end, not the current one.
  - cmd_* inputs are ignored while cmd_ready=0, and the requester must hold them.
  - At most one command is applied per frame.
- Register state on command apply:
  - The blink and breathe counters are shared and free-running; applying a command does not reset them.
  - A new mode takes the current bri and blink_phase as they stand.
- Reset during operation:
  - A pending command is discarded.
  - The LEDs go unlit asynchronously, because the led_out flops are reset.
  - After rst deasserts, the next frame begins at pwm_cnt=0.

Test Plan:
- All tests use TICK_DIV=2, BLINK_FRAMES=2 and LED_ACTIVE_LOW=0 unless stated otherwise.
- Reset, then idle 2000 cycles: led_out=0000 throughout, cmd_ready=1, frame_sync period is exactly 512 cycles.
- Steady-on duty: cmd LED0 ON level=128 -> from the applied frame onward, led_out[0] is high for 256 consecutive cycles and low for 256 per frame. Repeat with level=255 (constant high) and level=0 (constant low).
- Handshake back-to-back: cmd A (LED1 ON 64) then immediately cmd B (LED2 ON 200) -> cmd_ready stays low until A is applied at frame_end. B is accepted after that and applied one frame later. Exactly one mode change per frame.
- Blink: LED3 BLINK level=255 -> led_out[3] alternates 2 frames lit (constant high) and 2 frames dark. Toggles are aligned to frame_sync.
- Breathe: LED0 BREATHE level=100 -> per-frame high-cycle count is 2*min(bri,100). bri ramps 0..255..0, so lit time plateaus at 200 cycles while bri>=100. Check the turnaround sequence 254,255,254.
- Reset and polarity: assert rst while a command is pending -> cmd_ready=1 immediately and the command never takes effect. With LED_ACTIVE_LOW=1, reset gives led_out=1111, and ON level=255 drives 0.

Source files
------------

// File: rtl/led_pwm_ctrl_if.sv
// Command port for led_pwm_ctrl: one {led, mode, level} request per valid/ready handshake.
interface led_pwm_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_led;
    logic [1:0] cmd_mode;
    logic [7:0] cmd_level;

    modport master (
        output cmd_valid,
        output cmd_led,
        output cmd_mode,
        output cmd_level,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_led,
        input  cmd_mode,
        input  cmd_level,
        output cmd_ready
    );
endinterface

// File: rtl/led_pwm_ctrl.sv
// Four-LED PWM driver with off/on/blink/breathe modes; commands are queued in a
// single slot and applied only at PWM frame boundaries so outputs never glitch.
module led_pwm_ctrl #(
    parameter int TICK_DIV       = 3125,
    parameter int BLINK_FRAMES   = 125,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic               sys_clk,
    input  logic               rst,
    led_pwm_ctrl_if.slave      cmd,
    output logic               frame_sync,
    output logic [3:0]         led_out
);

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;

    typedef enum logic {ST_IDLE, ST_PEND} cmd_state_t;

    logic [TICK_W-1:0]  tick_cnt_p0;
    logic [7:0]         pwm_cnt_p0;
    logic               tick;
    logic               frame_end;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [7:0]         bri;
    logic               bri_down;
    logic [1:0]         mode_r  [4];
    logic [7:0]         level_r [4];
    logic [1:0]         pend_led;
    logic [1:0]         pend_mode;
    logic [7:0]         pend_level;
    cmd_state_t         state, state_nxt;
    logic               accept;
    logic               apply;
    logic [3:0]         lit_p0;

    function automatic logic [7:0] sat_min(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] eff_duty(input logic [1:0] mode, input logic [7:0] level,
                                            input logic phase, input logic [7:0] ramp);
        logic [7:0] d;
        d = 8'd0;
        case (mode)
            MODE_OFF:   d = 8'd0;
            MODE_ON:    d = level;
            MODE_BLINK: d = phase ? level : 8'd0;
            default:    d = sat_min(ramp, level);
        endcase
        return d;
    endfunction

    // Full scale is forced on so duty 255 has no one-tick dark gap per frame.
    function automatic logic is_lit(input logic [7:0] duty, input logic [7:0] pwm);
        return (duty == 8'hFF) || (pwm < duty);
    endfunction

    assign tick      = (tick_cnt_p0 == TICK_LAST);
    assign frame_end = tick && (pwm_cnt_p0 == 8'hFF);

    // ---- stage p0: prescaler, PWM counter and shared frame-rate effects ----
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            tick_cnt_p0 <= '0;
            pwm_cnt_p0  <= 8'd0;
            frame_sync  <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            bri         <= 8'd0;
            bri_down    <= 1'b0;
        end else begin
            tick_cnt_p0 <= tick ? '0 : tick_cnt_p0 + TICK_W'(1);
            if (tick)
                pwm_cnt_p0 <= pwm_cnt_p0 + 8'd1;
            frame_sync <= frame_end;
            if (frame_end) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
                // Triangle ramp: the end points are visited once, never repeated.
                if (!bri_down) begin
                    if (bri == 8'hFF) begin
                        bri_down <= 1'b1;
                        bri      <= 8'hFE;
                    end else begin
                        bri <= bri + 8'd1;
                    end
                end else if (bri == 8'd0) begin
                    bri_down <= 1'b0;
                    bri      <= 8'd1;
                end else begin
                    bri <= bri - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd.cmd_valid) state_nxt = ST_PEND;
            ST_PEND: if (frame_end)     state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A command accepted on a frame_end cycle lands in IDLE, so it waits a full frame.
    always_comb begin
        cmd.cmd_ready = (state == ST_IDLE);
        accept        = (state == ST_IDLE) && cmd.cmd_valid;
        apply         = (state == ST_PEND) && frame_end;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pend_led   <= 2'd0;
            pend_mode  <= MODE_OFF;
            pend_level <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                mode_r[i]  <= MODE_OFF;
                level_r[i] <= 8'd0;
            end
        end else begin
            if (accept) begin
                pend_led   <= cmd.cmd_led;
                pend_mode  <= cmd.cmd_mode;
                pend_level <= cmd.cmd_level;
            end
            if (apply) begin
                mode_r[pend_led]  <= pend_mode;
                level_r[pend_led] <= pend_level;
            end
        end
    end

    always_comb begin
        lit_p0 = 4'b0000;
        for (int i = 0; i < 4; i++)
            lit_p0[i] = is_lit(eff_duty(mode_r[i], level_r[i], blink_phase, bri), pwm_cnt_p0);
    end

    // ---- stage p1: registered LED drive with polarity applied ----
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) led_out <= {4{LED_ACTIVE_LOW}};
        else     led_out <= lit_p0 ^ {4{LED_ACTIVE_LOW}};
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl: random commands on an active-high instance checked every
// cycle against a frame-arithmetic model, plus a directed active-low breathe instance.
module tb_led_pwm_ctrl;

    localparam int TD_A = 2;
    localparam int BF_A = 2;
    localparam int TD_B = 1;
    localparam int BF_B = 2;
    localparam int A_CYCLES = 64000;
    localparam int B_FRAMES = 258;

    typedef struct {
        int led;
        int mode;
        int level;
        int gap;
    } cmd_t;

    logic       sys_clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic       fs_a, fs_b;
    logic [3:0] led_a, led_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sys_clk = ~sys_clk;

    led_pwm_ctrl_if if_a ();
    led_pwm_ctrl_if if_b ();

    led_pwm_ctrl #(.TICK_DIV(TD_A), .BLINK_FRAMES(BF_A), .LED_ACTIVE_LOW(1'b0)) dut_a (
        .sys_clk(sys_clk), .rst(rst_a), .cmd(if_a), .frame_sync(fs_a), .led_out(led_a));

    led_pwm_ctrl #(.TICK_DIV(TD_B), .BLINK_FRAMES(BF_B), .LED_ACTIVE_LOW(1'b1)) dut_b (
        .sys_clk(sys_clk), .rst(rst_b), .cmd(if_b), .frame_sync(fs_b), .led_out(led_b));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d required %0d at %0t", tag, obs, exp, $time);
    endtask

    // Breathe level of frame k: a 510-frame triangle 0..255..1.
    function automatic int tri_bri(input int k);
        int p;
        p = k % 510;
        return (p <= 255) ? p : 510 - p;
    endfunction

    function automatic int duty_of(input int mode, input int lev, input int k, input int bf);
        int b;
        b = tri_bri(k);
        case (mode)
            0: return 0;
            1: return lev;
            2: return (((k / bf) % 2) == 1) ? lev : 0;
            default: return (b < lev) ? b : lev;
        endcase
    endfunction

    function automatic bit lit_of(input int duty, input int pwm);
        return (duty == 255) || (pwm < duty);
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.led  = $urandom_range(0, 3);
        c.mode = $urandom_range(0, 3);
        case ($urandom_range(0, 3))
            0:       c.level = 0;
            1:       c.level = 255;
            2:       c.level = 254;
            default: c.level = $urandom_range(0, 255);
        endcase
        c.gap = $urandom_range(0, 1200);
        return c;
    endfunction

    task automatic run_a();
        cmd_t q[$];
        cmd_t cur, pc;
        int   m = 0;
        int   mmode[4];
        int   mlev[4];
        bit   pend = 1'b0;
        bit   drop = 1'b0;
        bit   rst_done = 1'b0;
        bit   fe;
        logic [3:0] exp_led = 4'b0000;
        bit   exp_fs = 1'b0;
        int   k, pwm;

        foreach (mmode[i]) begin mmode[i] = 0; mlev[i] = 0; end
        cur = '{0, 0, 0, 0};
        pc  = '{0, 0, 0, 0};
        q.push_back(cmd_t'{0, 1, 128, 2000});
        q.push_back(cmd_t'{0, 1, 255, 1200});
        q.push_back(cmd_t'{0, 1, 0,   1200});
        q.push_back(cmd_t'{1, 1, 64,  1200});
        q.push_back(cmd_t'{2, 1, 200, 0});
        q.push_back(cmd_t'{3, 2, 255, 1200});
        q.push_back(cmd_t'{0, 3, 100, 2500});

        if_a.cmd_valid = 1'b0;
        if_a.cmd_led   = 2'd0;
        if_a.cmd_mode  = 2'd0;
        if_a.cmd_level = 8'd0;
        repeat (3) @(negedge sys_clk);
        check_eq("a_rst_led", led_a, 4'b0000);
        check_eq("a_rst_ready", if_a.cmd_ready, 1);
        check_eq("a_rst_fsync", fs_a, 0);
        rst_a = 1'b0;

        for (int t = 0; t < A_CYCLES; t++) begin
            check_eq("a_led", led_a, exp_led);
            check_eq("a_ready", if_a.cmd_ready, !pend);
            check_eq("a_fsync", fs_a, exp_fs);

            // Mid-run reset with a command waiting in the slot.
            if (!rst_done && t >= 30000 && pend) begin
                rst_a = 1'b1;
                #1;
                check_eq("a_arst_ready", if_a.cmd_ready, 1);
                check_eq("a_arst_led", led_a, 4'b0000);
                repeat (2) @(negedge sys_clk);
                check_eq("a_arst_fsync", fs_a, 0);
                rst_a = 1'b0;
                m = 0; pend = 1'b0; drop = 1'b0; exp_led = 4'b0000; exp_fs = 1'b0;
                foreach (mmode[i]) begin mmode[i] = 0; mlev[i] = 0; end
                if_a.cmd_valid = 1'b0;
                rst_done = 1'b1;
            end

            if (drop) begin if_a.cmd_valid = 1'b0; drop = 1'b0; end
            if (!if_a.cmd_valid && t < A_CYCLES - 10) begin
                if (q.size() == 0) q.push_back(rand_cmd());
                if (q[0].gap > 0) begin
                    q[0].gap = q[0].gap - 1;
                end else begin
                    cur = q.pop_front();
                    if_a.cmd_led   = 2'(cur.led);
                    if_a.cmd_mode  = 2'(cur.mode);
                    if_a.cmd_level = 8'(cur.level);
                    if_a.cmd_valid = 1'b1;
                end
            end

            k   = m / (256 * TD_A);
            pwm = (m / TD_A) % 256;
            fe  = (m % (256 * TD_A)) == (256 * TD_A - 1);
            for (int i = 0; i < 4; i++)
                exp_led[i] = lit_of(duty_of(mmode[i], mlev[i], k, BF_A), pwm);
            exp_fs = fe;
            if (fe && pend) begin
                mmode[pc.led] = pc.mode;
                mlev[pc.led]  = pc.level;
                pend = 1'b0;
            end else if (if_a.cmd_valid && !pend) begin
                pend = 1'b1;
                pc   = cur;
                drop = 1'b1;
            end
            m++;
            @(negedge sys_clk);
        end
        check_eq("a_rst_exercised", rst_done, 1);
    endtask

    function automatic int exp_cnt_b(input int led, input int f);
        int b;
        b = tri_bri(f);
        case (led)
            0: return (f < 2) ? 0 : ((b < 100) ? b : 100) * TD_B;
            1: return (f < 1) ? 0 : 256 * TD_B;
            2: return (f < 3) ? 0 : ((b == 255) ? 256 : b) * TD_B;
            default: return 0;
        endcase
    endfunction

    task automatic run_b();
        cmd_t bq[3];
        int   acc_cyc[3];
        int   cnt[4];
        int   idx = 0;
        int   f;
        bit   acc_prev = 1'b0;

        bq[0] = cmd_t'{1, 1, 255, 0};
        bq[1] = cmd_t'{0, 3, 100, 0};
        bq[2] = cmd_t'{2, 3, 255, 0};
        foreach (acc_cyc[i]) acc_cyc[i] = -1;
        foreach (cnt[i]) cnt[i] = 0;

        if_b.cmd_valid = 1'b0;
        if_b.cmd_led   = 2'd0;
        if_b.cmd_mode  = 2'd0;
        if_b.cmd_level = 8'd0;
        repeat (3) @(negedge sys_clk);
        check_eq("b_rst_led", led_b, 4'b1111);
        check_eq("b_rst_ready", if_b.cmd_ready, 1);
        rst_b = 1'b0;
        if_b.cmd_led   = 2'(bq[0].led);
        if_b.cmd_mode  = 2'(bq[0].mode);
        if_b.cmd_level = 8'(bq[0].level);
        if_b.cmd_valid = 1'b1;

        for (int m = 0; m <= B_FRAMES * 256 * TD_B; m++) begin
            if (m >= 1) begin
                f = (m - 1) / (256 * TD_B);
                for (int i = 0; i < 4; i++) if (led_b[i] == 1'b0) cnt[i]++;
                if (((m - 1) % (256 * TD_B)) == 256 * TD_B - 1) begin
                    for (int i = 0; i < 4; i++) begin
                        check_eq($sformatf("b_lit_led%0d_frame%0d", i, f), cnt[i], exp_cnt_b(i, f));
                        cnt[i] = 0;
                    end
                end
            end
            if (acc_prev) begin
                acc_prev = 1'b0;
                idx++;
                if (idx < 3) begin
                    if_b.cmd_led   = 2'(bq[idx].led);
                    if_b.cmd_mode  = 2'(bq[idx].mode);
                    if_b.cmd_level = 8'(bq[idx].level);
                end else begin
                    if_b.cmd_valid = 1'b0;
                end
            end
            if (if_b.cmd_valid && if_b.cmd_ready && idx < 3) begin
                acc_cyc[idx] = m;
                acc_prev = 1'b1;
            end
            @(negedge sys_clk);
        end
        check_eq("b_accept0_cycle", acc_cyc[0], 0);
        check_eq("b_accept1_cycle", acc_cyc[1], 256 * TD_B);
        check_eq("b_accept2_cycle", acc_cyc[2], 512 * TD_B);
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
